drone_ctrl_top: RTL and testbench
=================================

Name: drone_ctrl_top

Overview:
- Top-level flight controller for a quadcopter.
- Receives single-byte flight commands over a UART line and converts them into per-motor duty targets.
- Slews each motor duty toward its target and drives four PWM outputs.
- Wakes the IMU over I2C after reset.
- Sits directly under the board top; all pins are board I/O.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD = 434.
- PWM_PERIOD, 1000, PWM period in clocks; duty range 0..PWM_PERIOD.
- HOVER_DUTY, 600, throttle duty after takeoff.
- TILT_DELTA, 100, duty offset applied for directional commands.
- RAMP_DIV, 10, clocks per 1-count duty step.
- I2C_QDIV, 125, clocks per SCL quarter period (100 kHz).

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, asynchronous reset, active-high (the name is kept for codebase consistency; asserted = 1).
- RxD, input, 1, UART receive line; idle high.
- scl, output, 1, I2C clock, open-drain (drives 0 or Z).
- sda, inout, 1, I2C data, open-drain (drives 0 or Z).
- pwm_1_out, output, 1, front-left motor PWM.
- pwm_2_out, output, 1, front-right motor PWM.
- pwm_3_out, output, 1, rear-left motor PWM.
- pwm_4_out, output, 1, rear-right motor PWM.

Behaviour:
- Reset: all pwm outputs 0, duties and targets 0, armed=0, scl/sda released (Z), UART FSM idle.
- RxD double-flop synchronized before use.
- UART receiver: 8N1, LSB first.
  - Falling edge starts reception; the line is re-sampled at CLKS_PER_BIT/2.
  - If the line is high at that re-sample, the start is treated as a glitch and the receiver returns to IDLE.
  - Data bits are sampled at each bit centre.
  - If the stop bit is sampled 0, the byte is discarded.
  - FSM states: IDLE, START, DATA, STOP.
  - A valid byte produces a 1-cycle byte_valid.
- Command decode (on byte_valid):
  - 0x01 takeoff: armed=1; all targets = HOVER_DUTY.
  - 0x00 level: all targets = HOVER_DUTY, applied only if armed.
  - 0x03 forward: motors 1,2 = HOVER-TILT; motors 3,4 = HOVER+TILT.
  - 0x04 back: mirror of forward.
  - 0x05 left: motors 1,3 = HOVER-TILT; motors 2,4 = HOVER+TILT.
  - 0x06 right: mirror of left.
  - 0x02 land: all targets = 0; armed clears when all four duties reach 0.
  - Codes 0x03–0x06 are ignored while disarmed; all other codes are always ignored.
  - A new command overrides the previous one immediately.
- Ramp:
  - A shared tick fires every RAMP_DIV clocks.
  - On each tick, each duty moves 1 count toward its target and holds when equal.
  - Duty is 10 bits, clamped to 0..PWM_PERIOD.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - Each pwm_k_out is registered as (counter < duty_k).
  - duty 0 gives constant low; duty PWM_PERIOD gives constant high.
  - A new duty takes effect at the next counter wrap to 0 (no glitches).
- I2C wake sequence:
  - Starts 1000 clocks after reset release.
  - Sequence: START, byte 0xD0, ACK, 0x6B, ACK, 0x00, ACK, STOP.
  - SDA changes only while SCL is low; it is sampled in the SCL-high quarter.
  - On NACK (SDA high at the ACK sample): STOP, wait 100000 clocks, retry the whole sequence.
  - After a fully ACKed sequence, stays DONE with scl and sda released.
  - FSM states: WAIT, START, BIT, ACK, STOP, RETRY, DONE.
- Reset mid-byte or mid-I2C: immediate return to reset state; a partial I2C transfer is abandoned.

Optional Feature:
- I2C_WAKE_EN defined: I2C wake FSM is built as described.
- I2C_WAKE_EN undefined: no I2C logic; scl and sda are permanently Z.
- The UART, decode, ramp and PWM paths are identical in both builds.

Test Plan:
- Reset pulse, RxD idle high → all pwm outputs 0 and scl/sda Z for 10 us.
- Send 0x01 (8.68 us/bit), wait 130 us → all four duties = 600; each pwm high 600 of every 1000 clocks.
- After takeoff, send 0x03, wait 20 us → motors 1,2 = 500, motors 3,4 = 700.
- Disarmed, send 0x03 → duties stay 0. Send byte with stop bit 0 → ignored. 2 us low glitch on RxD → no byte.
- Armed at 600, send 0x02 → duties ramp down 1 count per 10 clocks to 0, then armed=0; a following 0x03 is ignored.
- With I2C_WAKE_EN, pull-ups and a slave model ACKing → SDA carries 0xD0, 0x6B, 0x00 at 100 kHz, ending in STOP. A NACKing slave causes a retry after 2 ms.

Source files
------------

// File: rtl/drone_ctrl_top.sv
// drone_ctrl_top: quadcopter flight controller; UART byte commands become four slewed motor PWM outputs, and the IMU is woken over I2C.
// Ports:
//   clk                 system clock (50 MHz)
//   rst_n               asynchronous reset, active-high despite the name
//   RxD                 UART receive line, 8N1, LSB first, idle high
//   scl, sda            I2C open-drain clock and data (drive 0 or Z)
//   pwm_1_out..pwm_4_out motor PWM: 1 front-left, 2 front-right, 3 rear-left, 4 rear-right
// Define I2C_WAKE_EN to build the IMU wake sequencer; without it scl and sda are permanently released.
module drone_ctrl_top #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int PWM_PERIOD = 1000,
    parameter int HOVER_DUTY = 600,
    parameter int TILT_DELTA = 100,
    parameter int RAMP_DIV   = 10
`ifdef I2C_WAKE_EN
    ,
    parameter int I2C_QDIV   = 125
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RxD,
    output logic scl,
    inout  logic sda,
    output logic pwm_1_out,
    output logic pwm_2_out,
    output logic pwm_3_out,
    output logic pwm_4_out
);
    localparam int          CPB      = CLK_HZ / BAUD;
    localparam logic [15:0] BIT_END  = 16'(CPB - 1);
    localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);
    localparam logic [15:0] RAMP_END = 16'(RAMP_DIV - 1);
    localparam logic [9:0]  PER_END  = 10'(PWM_PERIOD - 1);
    localparam logic [9:0]  HOVER    = 10'(HOVER_DUTY > PWM_PERIOD ? PWM_PERIOD : HOVER_DUTY);
    localparam logic [9:0]  TILT_HI  = 10'(HOVER_DUTY + TILT_DELTA > PWM_PERIOD ? PWM_PERIOD : HOVER_DUTY + TILT_DELTA);
    localparam logic [9:0]  TILT_LO  = 10'(HOVER_DUTY > TILT_DELTA ? HOVER_DUTY - TILT_DELTA : 0);

    // rx_q[1:0] is the two-flop synchronizer; rx_q[2] is the previous synchronized level for edge detection
    logic [2:0] rx_q;
    logic       rx, rx_fall;
    assign rx      = rx_q[1];
    assign rx_fall = !rx_q[1] && rx_q[2];

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) rx_q <= 3'b111;
        else       rx_q <= {rx_q[1:0], RxD};

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_t;
    uart_t       u_state_q, u_state_d;
    logic [15:0] u_cnt_q, u_cnt_d;
    logic [2:0]  u_idx_q, u_idx_d;
    logic [7:0]  u_sh_q, u_sh_d;
    logic        u_tick, byte_valid_q, byte_valid_d;

    // START waits half a bit to land mid start bit; later states wait whole bits to land mid bit
    assign u_tick = u_cnt_q == (u_state_q == U_START ? HALF_END : BIT_END);

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            u_state_q    <= U_IDLE;
            u_cnt_q      <= '0;
            u_idx_q      <= '0;
            u_sh_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            u_state_q    <= u_state_d;
            u_cnt_q      <= u_cnt_d;
            u_idx_q      <= u_idx_d;
            u_sh_q       <= u_sh_d;
            byte_valid_q <= byte_valid_d;
        end

    always_comb begin
        u_state_d = u_state_q;
        u_cnt_d   = u_tick ? '0 : u_cnt_q + 16'd1;
        u_idx_d   = u_idx_q;
        u_sh_d    = u_sh_q;
        case (u_state_q)
            U_IDLE: begin
                u_cnt_d = '0;
                u_idx_d = '0;
                if (rx_fall) u_state_d = U_START;
            end
            U_START: if (u_tick) u_state_d = rx ? U_IDLE : U_DATA;
            U_DATA: if (u_tick) begin
                u_sh_d  = {rx, u_sh_q[7:1]};
                u_idx_d = u_idx_q + 3'd1;
                if (u_idx_q == 3'd7) u_state_d = U_STOP;
            end
            default: if (u_tick) u_state_d = U_IDLE;
        endcase
    end

    // a low stop bit discards the byte
    always_comb byte_valid_d = u_state_q == U_STOP && u_tick && rx;

    logic [7:0]       cmd;
    logic             take, level, dir, land, all_zero, ramp_tick, pwm_wrap;
    logic             armed_q, armed_d, land_q, land_d;
    logic [3:0]       neg;
    logic [3:0][9:0]  tgt_q, tgt_d, duty_q, duty_d, act_q;
    logic [15:0]      rdiv_q;
    logic [9:0]       pcnt_q;
    logic [3:0]       pwm_q;

    assign cmd       = u_sh_q;
    assign ramp_tick = rdiv_q == RAMP_END;
    assign pwm_wrap  = pcnt_q == PER_END;

    always_comb begin
        take     = byte_valid_q && cmd == 8'h01;
        level    = byte_valid_q && cmd == 8'h00 && armed_q;
        dir      = byte_valid_q && armed_q && cmd >= 8'h03 && cmd <= 8'h06;
        land     = byte_valid_q && cmd == 8'h02;
        // bit k set: motor k+1 gets the reduced duty for this directional command
        neg      = cmd == 8'h03 ? 4'b0011 : cmd == 8'h04 ? 4'b1100 : cmd == 8'h05 ? 4'b0101 : 4'b1010;
        all_zero = duty_q == '0;
        // landing disarms only once every motor has actually spun down
        armed_d  = take || (armed_q && !(land_q && all_zero));
        land_d   = land || (land_q && !(take || level || dir || all_zero));
        for (int k = 0; k < 4; k++) begin
            tgt_d[k]  = take || level ? HOVER : dir ? (neg[k] ? TILT_LO : TILT_HI) : land ? 10'd0 : tgt_q[k];
            duty_d[k] = !ramp_tick || duty_q[k] == tgt_q[k] ? duty_q[k] :
                        duty_q[k] < tgt_q[k] ? duty_q[k] + 10'd1 : duty_q[k] - 10'd1;
        end
    end

    // act_q is the duty in force for the current PWM period; it only reloads at wrap so no period is cut short
    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            armed_q <= 1'b0;
            land_q  <= 1'b0;
            tgt_q   <= '0;
            duty_q  <= '0;
            act_q   <= '0;
            rdiv_q  <= '0;
            pcnt_q  <= '0;
            pwm_q   <= '0;
        end else begin
            armed_q <= armed_d;
            land_q  <= land_d;
            tgt_q   <= tgt_d;
            duty_q  <= duty_d;
            rdiv_q  <= ramp_tick ? '0 : rdiv_q + 16'd1;
            pcnt_q  <= pwm_wrap ? '0 : pcnt_q + 10'd1;
            if (pwm_wrap) act_q <= duty_q;
            for (int k = 0; k < 4; k++) pwm_q[k] <= pcnt_q < act_q[k];
        end

    assign pwm_1_out = pwm_q[0];
    assign pwm_2_out = pwm_q[1];
    assign pwm_3_out = pwm_q[2];
    assign pwm_4_out = pwm_q[3];

`ifdef I2C_WAKE_EN
    typedef enum logic [2:0] {I_WAIT, I_START, I_BIT, I_ACK, I_STOP, I_RETRY, I_DONE} i2c_t;
    localparam logic [16:0] Q_END     = 17'(I2C_QDIV - 1);
    localparam logic [16:0] WAIT_END  = 17'd999;
    localparam logic [16:0] RETRY_END = 17'd99999;

    i2c_t        i_state_q, i_state_d;
    logic [16:0] i_cnt_q, i_cnt_d;
    logic [1:0]  i_ph_q, i_ph_d, i_byte_q, i_byte_d;
    logic [2:0]  i_bit_q, i_bit_d;
    logic [7:0]  cur_byte;
    logic        i_nack_q, i_nack_d, scl_q, scl_d, sda_q, sda_d, q_end, slot_end, cur_bit;

    // each bit slot is four quarters: SCL low (hold), SCL low (SDA updates), SCL high (sampled at end), SCL high
    assign q_end    = i_cnt_q == Q_END;
    assign slot_end = q_end && i_ph_q == 2'd3;
    assign cur_byte = i_byte_q == 2'd0 ? 8'hD0 : i_byte_q == 2'd1 ? 8'h6B : 8'h00;
    assign cur_bit  = cur_byte[~i_bit_q];

    always_ff @(posedge clk or posedge rst_n)
        if (rst_n) begin
            i_state_q <= I_WAIT;
            i_cnt_q   <= '0;
            i_ph_q    <= '0;
            i_bit_q   <= '0;
            i_byte_q  <= '0;
            i_nack_q  <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            i_state_q <= i_state_d;
            i_cnt_q   <= i_cnt_d;
            i_ph_q    <= i_ph_d;
            i_bit_q   <= i_bit_d;
            i_byte_q  <= i_byte_d;
            i_nack_q  <= i_nack_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end

    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q + 17'd1;
        i_ph_d    = i_ph_q;
        i_bit_d   = i_bit_q;
        i_byte_d  = i_byte_q;
        i_nack_d  = i_nack_q;
        case (i_state_q)
            I_WAIT, I_RETRY: if (i_cnt_q == (i_state_q == I_WAIT ? WAIT_END : RETRY_END)) begin
                i_state_d = I_START;
                i_cnt_d   = '0;
            end
            I_DONE: i_cnt_d = i_cnt_q;
            default: begin
                if (q_end) begin
                    i_cnt_d = '0;
                    i_ph_d  = i_ph_q + 2'd1;
                end
                if (i_state_q == I_ACK && q_end && i_ph_q == 2'd2) i_nack_d = sda;
                if (slot_end)
                    case (i_state_q)
                        I_START: begin
                            i_state_d = I_BIT;
                            i_bit_d   = '0;
                            i_byte_d  = '0;
                            i_nack_d  = 1'b0;
                        end
                        I_BIT: begin
                            i_bit_d = i_bit_q + 3'd1;
                            if (i_bit_q == 3'd7) i_state_d = I_ACK;
                        end
                        I_ACK: begin
                            i_byte_d  = i_byte_q + 2'd1;
                            i_state_d = i_nack_q || i_byte_q == 2'd2 ? I_STOP : I_BIT;
                        end
                        default: i_state_d = i_nack_q ? I_RETRY : I_DONE;
                    endcase
            end
        endcase
    end

    // START drops SDA with SCL high; STOP raises SDA in the last SCL-high quarter
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (i_state_q)
            I_START: sda_d = !i_ph_q[1];
            I_BIT: begin
                scl_d = i_ph_q[1];
                sda_d = i_ph_q == 2'd0 ? sda_q : cur_bit;
            end
            I_ACK: begin
                scl_d = i_ph_q[1];
                sda_d = i_ph_q == 2'd0 ? sda_q : 1'b1;
            end
            I_STOP: begin
                scl_d = i_ph_q[1];
                sda_d = i_ph_q == 2'd0 ? sda_q : i_ph_q == 2'd3;
            end
            default: ;
        endcase
    end

    assign scl = scl_q ? 1'bz : 1'b0;
    assign sda = sda_q ? 1'bz : 1'b0;
`else
    assign scl = 1'bz;
    assign sda = 1'bz;
`endif
endmodule

// File: tb/tb_drone_ctrl_top.sv
// tb_drone_ctrl_top: directed bench for drone_ctrl_top (default build, no I2C) using UART byte stimulus and PWM duty measurement.
module tb_drone_ctrl_top;
    localparam int BIT = 434;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RxD = 1'b1;
    logic mon_on = 1'b0;
    wire  scl_w, sda_w;
    logic pwm1, pwm2, pwm3, pwm4;
    int   total = 0;
    int   bad = 0;
    int   nbytes = 0;
    int   i2c_low = 0;
    int   hc [4];

    pullup (scl_w);
    pullup (sda_w);

    always #10 clk = ~clk;

    drone_ctrl_top dut (
        .clk(clk), .rst_n(rst_n), .RxD(RxD), .scl(scl_w), .sda(sda_w),
        .pwm_1_out(pwm1), .pwm_2_out(pwm2), .pwm_3_out(pwm3), .pwm_4_out(pwm4)
    );

    always @(posedge clk) if (dut.byte_valid_q === 1'b1) nbytes++;
    always @(negedge clk) if (mon_on && (scl_w !== 1'b1 || sda_w !== 1'b1)) i2c_low++;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        RxD = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (BIT) @(negedge clk);
        end
        RxD = stop;
        repeat (BIT) @(negedge clk);
        RxD = 1'b1;
    endtask

    task automatic measure();
        for (int k = 0; k < 4; k++) hc[k] = 0;
        repeat (1000) begin
            @(negedge clk);
            hc[0] += int'(pwm1);
            hc[1] += int'(pwm2);
            hc[2] += int'(pwm3);
            hc[3] += int'(pwm4);
        end
    endtask

    task automatic test_reset();
        int hi_cycles = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({pwm1, pwm2, pwm3, pwm4} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pwm_in_reset: got %b want 0000", {pwm1, pwm2, pwm3, pwm4});
        end
        rst_n = 1'b0;
        mon_on = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if ({pwm1, pwm2, pwm3, pwm4} !== 4'b0000) hi_cycles++;
        end
        total++;
        if (hi_cycles !== 0) begin
            bad++;
            $display("FAIL reset_pwm_idle: %0d cycles with a pwm high, want 0", hi_cycles);
        end
        total++;
        if (scl_w !== 1'b1 || sda_w !== 1'b1) begin
            bad++;
            $display("FAIL reset_i2c_released: scl=%b sda=%b want both released (1)", scl_w, sda_w);
        end
    endtask

    task automatic test_disarmed_dir();
        send_byte(8'h03, 1'b1);
        repeat (1500) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 0) begin
                bad++;
                $display("FAIL disarmed_fwd motor%0d: high %0d of 1000 want 0", k + 1, hc[k]);
            end
        end
        total++;
        if (nbytes !== 1) begin
            bad++;
            $display("FAIL disarmed_fwd_bytes: got %0d want 1", nbytes);
        end
    endtask

    task automatic test_bad_stop();
        send_byte(8'h01, 1'b0);
        repeat (1500) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 0) begin
                bad++;
                $display("FAIL bad_stop motor%0d: high %0d of 1000 want 0", k + 1, hc[k]);
            end
        end
        total++;
        if (nbytes !== 1) begin
            bad++;
            $display("FAIL bad_stop_bytes: got %0d want 1", nbytes);
        end
    endtask

    task automatic test_glitch_takeoff();
        @(negedge clk);
        RxD = 1'b0;
        repeat (100) @(negedge clk);
        RxD = 1'b1;
        repeat (400) @(negedge clk);
        send_byte(8'h01, 1'b1);
        repeat (7000) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 600) begin
                bad++;
                $display("FAIL takeoff motor%0d: high %0d of 1000 want 600", k + 1, hc[k]);
            end
        end
        total++;
        if (nbytes !== 2) begin
            bad++;
            $display("FAIL glitch_bytes: got %0d want 2", nbytes);
        end
    endtask

    task automatic test_forward();
        int exp_d [4] = '{500, 500, 700, 700};
        send_byte(8'h03, 1'b1);
        repeat (2200) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== exp_d[k]) begin
                bad++;
                $display("FAIL forward motor%0d: high %0d of 1000 want %0d", k + 1, hc[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_d [4] = '{500, 700, 500, 700};
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        repeat (3300) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== exp_d[k]) begin
                bad++;
                $display("FAIL back_then_left motor%0d: high %0d of 1000 want %0d", k + 1, hc[k], exp_d[k]);
            end
        end
        total++;
        if (nbytes !== 5) begin
            bad++;
            $display("FAIL back_to_back_bytes: got %0d want 5", nbytes);
        end
    endtask

    task automatic test_level();
        send_byte(8'h00, 1'b1);
        repeat (2300) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 600) begin
                bad++;
                $display("FAIL level motor%0d: high %0d of 1000 want 600", k + 1, hc[k]);
            end
        end
    endtask

    task automatic test_land();
        int d0, d3;
        send_byte(8'h02, 1'b1);
        repeat (2000) @(negedge clk);
        d0 = int'(dut.duty_q[0]);
        d3 = int'(dut.duty_q[3]);
        total++;
        if (d0 < 375 || d0 > 382) begin
            bad++;
            $display("FAIL land_ramp_rate motor1: duty %0d want 375..382", d0);
        end
        total++;
        if (d3 !== d0) begin
            bad++;
            $display("FAIL land_ramp_even motor4: duty %0d want %0d (same as motor1)", d3, d0);
        end
        repeat (5200) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 0) begin
                bad++;
                $display("FAIL landed motor%0d: high %0d of 1000 want 0", k + 1, hc[k]);
            end
        end
        send_byte(8'h03, 1'b1);
        repeat (2500) @(negedge clk);
        measure();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (hc[k] !== 0) begin
                bad++;
                $display("FAIL fwd_after_land motor%0d: high %0d of 1000 want 0", k + 1, hc[k]);
            end
        end
    endtask

    task automatic test_i2c_idle();
        total++;
        if (i2c_low !== 0) begin
            bad++;
            $display("FAIL i2c_never_driven: %0d cycles with scl/sda low want 0", i2c_low);
        end
    endtask

    initial begin
        test_reset();
        test_disarmed_dir();
        test_bad_stop();
        test_glitch_takeoff();
        test_forward();
        test_back_to_back();
        test_level();
        test_land();
        test_i2c_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
